// File: rtl/kpyd_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
// Scan-state and result-kind enums plus the legacy 4x4 hex legend.
package kpyd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD,
        ST_EVAL
    } scan_state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } result_t;

    // Legacy legend: row0 1 2 3 A, row1 4 5 6 B, row2 7 8 9 C, row3 0 F E D.
    function automatic logic [3:0] kpyd_hex(input logic [3:0] code);
        logic [3:0] h;
        case (code)
            4'd0:    h = 4'h1;
            4'd1:    h = 4'h2;
            4'd2:    h = 4'h3;
            4'd3:    h = 4'hA;
            4'd4:    h = 4'h4;
            4'd5:    h = 4'h5;
            4'd6:    h = 4'h6;
            4'd7:    h = 4'hB;
            4'd8:    h = 4'h7;
            4'd9:    h = 4'h8;
            4'd10:   h = 4'h9;
            4'd11:   h = 4'hC;
            4'd12:   h = 4'h0;
            4'd13:   h = 4'hF;
            4'd14:   h = 4'hE;
            default: h = 4'hD;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/kpyd_debounce.sv
// Whole-scan debouncer: tracks candidate/match count/stable state and
// emits a combinational press event during the accepting EVAL cycle.
module kpyd_debounce
    import kpyd_pkg::*;
#(
    parameter int KW             = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eval,
    input  result_t       res_kind,
    input  logic [KW-1:0] res_code,
    output logic          evt,
    output logic [KW-1:0] evt_code,
    output logic          held
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    result_t       cand_kind, stable_kind;
    logic [KW-1:0] cand_code, stable_code;
    logic [CW-1:0] count, nxt_count;
    logic          same, accept;

    always_comb begin
        same      = (res_kind == cand_kind) && (res_code == cand_code);
        nxt_count = CW'(1);
        if (same) begin
            nxt_count = (count == CNT_MAX) ? count : count + CW'(1);
        end
        // Accept on the very EVAL that completes the run so the event is not delayed.
        accept   = eval && (nxt_count == CNT_MAX) &&
                   ((res_kind != stable_kind) || (res_code != stable_code));
        evt      = accept && (res_kind == RES_SINGLE);
        evt_code = res_code;
        held     = (stable_kind == RES_SINGLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_kind   <= RES_NONE;
            cand_code   <= '0;
            count       <= '0;
            stable_kind <= RES_NONE;
            stable_code <= '0;
        end else if (eval) begin
            cand_kind <= res_kind;
            cand_code <= res_code;
            count     <= nxt_count;
            if (accept) begin
                stable_kind <= res_kind;
                stable_code <= res_code;
            end
        end
    end

endmodule

// File: rtl/kpyd_scanner.sv
// Matrix-keypad scanner: column strobing, row synchronisation, scan
// classification and a one-entry event buffer with sticky overrun.
module kpyd_scanner
    import kpyd_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int COL_CYCLES     = 100000,
    parameter int SETTLE_CYCLES  = 8,
    parameter int DEBOUNCE_SCANS = 3,
    localparam int KW            = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row_i,
    output logic [COLS-1:0] col_o,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [KW-1:0]   key_code,
    output logic            key_held,
    output logic            overrun
);

    localparam int N    = ROWS * COLS;
    localparam int CTW  = $clog2(COL_CYCLES);
    localparam int COLW = $clog2(COLS);

    scan_state_t      state, nxt_state;
    logic [CTW-1:0]   cnt;
    logic [COLW-1:0]  col;
    logic [N-1:0]     acc;
    logic [ROWS-1:0]  sync1, sync2;
    logic             last_cnt, last_col;
    logic [1:0]       n_low;
    logic [KW-1:0]    low_idx;
    result_t          res_kind;
    logic [KW-1:0]    res_code;
    logic             evt;
    logic [KW-1:0]    evt_code;

    assign last_cnt = (cnt == CTW'(COL_CYCLES - 1));
    assign last_col = (col == COLW'(COLS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        col_o     = '1;
        case (state)
            ST_IDLE:   nxt_state = ST_DRIVE;
            ST_DRIVE:  nxt_state = ST_SETTLE;
            ST_SETTLE: if (cnt == CTW'(SETTLE_CYCLES - 1)) nxt_state = ST_SAMPLE;
            ST_SAMPLE: nxt_state = ST_HOLD;
            ST_HOLD:   if (last_cnt) nxt_state = last_col ? ST_EVAL : ST_DRIVE;
            default:   nxt_state = ST_DRIVE;
        endcase
        if (state != ST_IDLE && state != ST_EVAL) begin
            for (int c = 0; c < COLS; c++) begin
                if (col == COLW'(c)) col_o[c] = 1'b0;
            end
        end
    end

    // Classification: count low bits (saturating at 2) and remember the last one.
    always_comb begin
        n_low   = 2'd0;
        low_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (n_low != 2'd2) n_low = n_low + 2'd1;
                low_idx = KW'(i);
            end
        end
        res_kind = (n_low == 2'd0) ? RES_NONE : (n_low == 2'd1) ? RES_SINGLE : RES_MULTI;
        res_code = (n_low == 2'd1) ? low_idx : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            cnt   <= '0;
            col   <= '0;
            acc   <= '0;
        end else begin
            sync1 <= row_i;
            sync2 <= sync1;
            case (state)
                ST_DRIVE, ST_SETTLE: cnt <= cnt + CTW'(1);
                ST_SAMPLE: begin
                    cnt <= cnt + CTW'(1);
                    for (int c = 0; c < COLS; c++) begin
                        if (col == COLW'(c)) begin
                            for (int r = 0; r < ROWS; r++) acc[r*COLS + c] <= ~sync2[r];
                        end
                    end
                end
                ST_HOLD: begin
                    if (last_cnt) begin
                        cnt <= '0;
                        col <= last_col ? '0 : col + COLW'(1);
                    end else begin
                        cnt <= cnt + CTW'(1);
                    end
                end
                ST_EVAL: begin
                    cnt <= '0;
                    acc <= '0;
                end
                default: cnt <= '0;
            endcase
        end
    end

    kpyd_debounce #(
        .KW             (KW),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .eval     (state == ST_EVAL),
        .res_kind (res_kind),
        .res_code (res_code),
        .evt      (evt),
        .evt_code (evt_code),
        .held     (key_held)
    );

    // Handshake: an event transfers on a cycle where key_valid && key_ready;
    // key_code only changes when the buffer is empty or being drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            overrun   <= 1'b0;
        end else if (evt) begin
            if (!key_valid || key_ready) begin
                key_valid <= 1'b1;
                key_code  <= evt_code;
            end else begin
                overrun <= 1'b1;
            end
        end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kpyd_scanner.sv
// Bench for kpyd_scanner: keypad model, table of single-key presses,
// hand-written corner sequences and a queue-based event scoreboard.
module tb_kpyd_scanner;
    import kpyd_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] key_code;
    logic       key_held;
    logic       overrun;
    logic [15:0] keys;

    int total = 0;
    int bad = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        int         key;
        logic [3:0] hex;
    } vec_t;
    vec_t vecs[5];

    kpyd_scanner #(
        .ROWS(4), .COLS(4), .COL_CYCLES(16), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3)
    ) dut (
        .clk(clk), .rst(rst), .row_i(row_i), .col_o(col_o),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_held(key_held), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Keypad model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_i = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && !col_o[c]) row_i[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted transfer is compared with the oldest expected code.
    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got code %0d expected none", key_code);
            end else begin
                check("event_code", key_code, exp_q.pop_front());
            end
        end
    end

    task automatic wait_eval();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (col_o !== 4'b1111 && n < 200);
        if (n >= 200) check("eval_timeout", 32'(col_o), 32'hF);
    endtask

    task automatic wait_evals(input int k);
        for (int i = 0; i < k; i++) wait_eval();
    endtask

    initial begin
        vecs[0] = '{9,  4'h8};
        vecs[1] = '{3,  4'hA};
        vecs[2] = '{12, 4'h0};
        vecs[3] = '{6,  4'h6};
        vecs[4] = '{15, 4'hD};

        rst = 1'b1; keys = '0; key_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_col_o", 32'(col_o), 32'hF);
        check("rst_key_valid", 32'(key_valid), 0);
        check("rst_key_code", 32'(key_code), 0);
        check("rst_key_held", 32'(key_held), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("first_drive", 32'(col_o), 32'hE);

        // Asynchronous reset in the middle of a scan.
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midscan_rst_col_o", 32'(col_o), 32'hF);
        check("midscan_rst_valid", 32'(key_valid), 0);
        check("midscan_rst_overrun", 32'(overrun), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("restart_drive", 32'(col_o), 32'hE);

        // Single-key presses from the table: latency, code, legend, release.
        for (int v = 0; v < 5; v++) begin
            wait_eval();
            exp_q.push_back(4'(vecs[v].key));
            keys[vecs[v].key] = 1'b1;
            wait_evals(2);
            check("held_before_accept", 32'(key_held), 0);
            wait_eval();
            check("valid_at_third_eval", 32'(key_valid), 0);
            @(negedge clk);
            check("valid_after_eval", 32'(key_valid), 1);
            check("key_code", 32'(key_code), 32'(vecs[v].key));
            check("key_held", 32'(key_held), 1);
            check("hex_legend", 32'(kpyd_hex(key_code)), 32'(vecs[v].hex));
            wait_evals(2);
            keys = '0;
            wait_evals(4);
            check("held_after_release", 32'(key_held), 0);
            check("valid_after_release", 32'(key_valid), 0);
        end

        // Bounce: toggle every 40 cycles for four scans, then hold.
        wait_eval();
        for (int i = 0; i < 260; i++) begin
            keys[9] = ((i / 40) % 2 == 0);
            @(negedge clk);
        end
        check("bounce_no_hold", 32'(key_held), 0);
        exp_q.push_back(4'd9);
        keys[9] = 1'b1;
        wait_evals(4);
        check("bounce_held", 32'(key_held), 1);
        check("bounce_event_seen", 32'(exp_q.size()), 0);
        keys = '0;
        wait_evals(4);

        // Two keys held: MULTI, then release one.
        wait_eval();
        keys[0] = 1'b1; keys[5] = 1'b1;
        wait_evals(5);
        check("multi_held", 32'(key_held), 0);
        exp_q.push_back(4'd0);
        keys[5] = 1'b0;
        wait_evals(4);
        check("multi_release_held", 32'(key_held), 1);
        check("multi_release_event", 32'(exp_q.size()), 0);
        keys = '0;
        wait_evals(4);

        // Overrun: consumer stalled while a second key is pressed.
        key_ready = 1'b0;
        wait_eval();
        exp_q.push_back(4'd3);
        keys[3] = 1'b1;
        wait_evals(4);
        keys = '0;
        wait_evals(4);
        keys[12] = 1'b1;
        wait_evals(4);
        check("ovr_valid", 32'(key_valid), 1);
        check("ovr_code", 32'(key_code), 3);
        check("ovr_flag", 32'(overrun), 1);
        key_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("ovr_drained", 32'(key_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);
        keys = '0;
        wait_evals(4);

        // Slide directly from code 7 to code 14.
        wait_eval();
        exp_q.push_back(4'd7);
        keys[7] = 1'b1;
        wait_evals(4);
        exp_q.push_back(4'd14);
        keys = '0; keys[14] = 1'b1;
        wait_evals(4);
        check("slide_held", 32'(key_held), 1);
        keys = '0;
        wait_evals(4);
        check("all_events_seen", 32'(exp_q.size()), 0);

        // Reset with an event pending discards it and clears overrun.
        key_ready = 1'b0;
        wait_eval();
        keys[6] = 1'b1;
        wait_evals(4);
        check("pending_valid", 32'(key_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("pending_lost", 32'(key_valid), 0);
        check("rst_clears_overrun", 32'(overrun), 0);
        check("rst_clears_held", 32'(key_held), 0);
        keys = '0;
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
